// File: rtl/clm_rand_source.sv
// Per-encryption randomness for the CLM AES core: a stable output set plus a shadow set refilled from a seeded LFSR.
// Define CLM_RAND_FIXED_EN to replace the LFSR with constant bytes and a constant p_det (test builds).
module clm_rand_source #(
   parameter int                 N_RAND       = 23,
   parameter int                 P_COUNT      = 30,
   parameter int                 LFSR_W       = 32,
   parameter logic [LFSR_W-1:0]  LFSR_TAPS    = 32'h8020_0003,
   parameter logic [LFSR_W-1:0]  SEED_DEFAULT = 32'hACE1_2468,
   parameter logic [7:0]         FIXED_BYTE   = 8'd109,
   parameter logic [4:0]         FIXED_P      = 5'd15
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    seed_load_i,
   input  logic [LFSR_W-1:0]       seed_i,
   input  logic                    take_i,
   output logic                    valid_o,
   output logic [0:N_RAND-1][7:0]  random_vect_o,
   output logic [4:0]              p_det_o,
   output logic                    busy_o,
   output logic                    dbg_state_o
);

   typedef enum logic {S_FILL = 1'b0, S_READY = 1'b1} state_t;

   state_t                   state, state_nxt;
   logic [0:N_RAND-1][7:0]   shadow;
   logic [4:0]               shadow_p;
   logic                     fill_done;
   logic                     take;

   // Handshake: a take completes on any edge where take_i && valid_o, unless seed_load_i is also high.
   assign take = take_i && valid_o && !seed_load_i;

`ifdef CLM_RAND_FIXED_EN
   logic unused_seed;
   assign unused_seed = ^seed_i;
   assign fill_done   = 1'b1;
`else
   localparam int              IDX_W    = $clog2(N_RAND + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_RAND);
   localparam logic [5:0]      P_LIM    = 6'(P_COUNT);

   logic [LFSR_W-1:0] lfsr, lfsr_nxt;
   logic [IDX_W-1:0]  idx;
   logic              idx_full, byte_ok, p_ok;

   always_comb begin
      lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
      idx_full = (idx == IDX_LAST);
      byte_ok  = (lfsr_nxt[7:0] != 8'd0);
      p_ok     = ({1'b0, lfsr_nxt[4:0]} < P_LIM);
   end

   assign fill_done = idx_full && p_ok;

   // The LFSR steps only while filling, so a held READY set costs no entropy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         lfsr <= SEED_DEFAULT;
      else if (seed_load_i)
         lfsr <= (seed_i == '0) ? SEED_DEFAULT : seed_i;
      else if (state == S_FILL)
         lfsr <= lfsr_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         idx <= '0;
      else if (seed_load_i || take)
         idx <= '0;
      else if (state == S_FILL && !idx_full && byte_ok)
         idx <= idx + 1'b1;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= S_FILL;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (seed_load_i)
         state_nxt = S_FILL;
      else if (state == S_FILL && fill_done)
         state_nxt = S_READY;
      else if (take)
         state_nxt = S_FILL;
   end

   always_comb begin
      valid_o     = (state == S_READY);
      busy_o      = (state == S_FILL);
      dbg_state_o = state;
   end

   // Outputs move only on a take; a seed load simply abandons the shadow contents.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow        <= '0;
         shadow_p      <= '0;
         random_vect_o <= '0;
         p_det_o       <= '0;
      end else if (!seed_load_i) begin
         if (state == S_FILL) begin
`ifdef CLM_RAND_FIXED_EN
            shadow   <= {N_RAND{FIXED_BYTE}};
            shadow_p <= FIXED_P;
`else
            if (!idx_full && byte_ok)
               shadow[idx] <= lfsr_nxt[7:0];
            if (idx_full && p_ok)
               shadow_p <= lfsr_nxt[4:0];
`endif
         end else if (take_i) begin
            random_vect_o <= shadow;
            p_det_o       <= shadow_p;
         end
      end
   end

endmodule

// File: tb/tb_clm_rand_source.sv
// Randomised scoreboard bench for clm_rand_source against a draw-by-draw reference model.
`timescale 1ns/1ps
module tb_clm_rand_source;
   localparam int          N_RAND   = 23;
   localparam int          W        = N_RAND * 8 + 5;
   localparam logic [31:0] TAPS     = 32'h8020_0003;
   localparam logic [31:0] SEED_DEF = 32'hACE1_2468;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic                   seed_load_i = 1'b0;
   logic [31:0]            seed_i = '0;
   logic                   take_i = 1'b0;
   logic                   valid_o, busy_o, dbg_state_o;
   logic [0:N_RAND-1][7:0] random_vect_o;
   logic [4:0]             p_det_o;

   logic [W-1:0] exp_q[$];
   int           n_checks = 0;
   int           n_fail = 0;
   logic [31:0]  m_lfsr;
   logic [W-1:0] cur_set, cur_out, def_set;
   int           m_cyc, m_brej, m_prej;
   logic         pending = 1'b0;

   clm_rand_source dut (
      .clk(clk), .rst(rst), .seed_load_i(seed_load_i), .seed_i(seed_i), .take_i(take_i),
      .valid_o(valid_o), .random_vect_o(random_vect_o), .p_det_o(p_det_o),
      .busy_o(busy_o), .dbg_state_o(dbg_state_o)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: draw bytes until N_RAND nonzero ones are collected, then draw p until one is below 30.
   task automatic model_fill(input logic [31:0] s_start, output logic [31:0] s_end,
                             output logic [W-1:0] set, output int cyc,
                             output int brej, output int prej);
      logic [31:0] s;
      int          n;
      s = s_start; n = 0; cyc = 0; brej = 0; prej = 0; set = '0;
      while (cyc < 1000) begin
         s = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
         cyc++;
         if (n < N_RAND) begin
            if (s[7:0] == 8'd0) brej++;
            else begin
               set[W-1-8*n -: 8] = s[7:0];
               n++;
            end
         end else if (s[4:0] < 5'd30) begin
            set[4:0] = s[4:0];
            break;
         end else prej++;
      end
      s_end = s;
   endtask

   // driver tasks
   task automatic wait_valid(input bit poke, output int cyc);
      cyc = 0;
      while (!valid_o && cyc < 300) begin
         take_i = poke && (cyc >= 1) && (cyc < 4);
         @(posedge clk); #1;
         cyc++;
      end
      take_i = 1'b0;
      if (!valid_o) begin
         n_checks++;
         n_fail++;
         $display("FAIL valid_timeout: valid_o still 0 after %0d cycles", cyc);
      end
   endtask

   task automatic next_fill(input bit poke, output int cyc);
      model_fill(m_lfsr, m_lfsr, cur_set, m_cyc, m_brej, m_prej);
      wait_valid(poke, cyc);
      check_int("fill_len", cyc, m_cyc);
      check("hold_during_fill", {random_vect_o, p_det_o}, cur_out);
      check_int("busy_in_ready", int'(busy_o), 0);
   endtask

   task automatic do_take();
      exp_q.push_back(cur_set);
      cur_out = cur_set;
      take_i = 1'b1;
      @(posedge clk); #1;
      take_i = 1'b0;
   endtask

   task automatic load_seed(input logic [31:0] s);
      seed_i = s;
      seed_load_i = 1'b1;
      @(posedge clk); #1;
      seed_load_i = 1'b0;
      m_lfsr = (s == 32'd0) ? SEED_DEF : s;
      check_int("valid_after_seed", int'(valid_o), 0);
   endtask

   // scoreboard monitor
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         if (pending) begin
            pending = 1'b0;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_take: outputs %h with empty queue", {random_vect_o, p_det_o});
            end else begin
               e = exp_q.pop_front();
               check("take_data", {random_vect_o, p_det_o}, e);
               check_int("take_valid", int'(valid_o), 0);
               check_int("take_busy", int'(busy_o), 1);
            end
         end
         if (rst && take_i && valid_o && !seed_load_i) pending = 1'b1;
      end
   end

   initial begin
      int          cyc, zeros, found;
      logic [31:0] s, s_end;
      logic [W-1:0] tmp_set;
      int          c, br, pr;

      // T1 reset and first fill from the default seed
      repeat (2) @(posedge clk); #1;
      check("reset_out", {random_vect_o, p_det_o}, '0);
      check_int("reset_valid", int'(valid_o), 0);
      rst = 1'b1;
      m_lfsr = SEED_DEF;
      cur_out = '0;
      #1 check_int("busy_after_release", int'(busy_o), 1);
      next_fill(1'b0, cyc);
      def_set = cur_set;

      // T2 takes, with ignored takes during the refill
      do_take();
      next_fill(1'b1, cyc);
      do_take();
      next_fill(1'b0, cyc);

      // T3 seed forcing one zero byte and one out-of-range p draw
      found = 0;
      s = 32'd1;
      for (int i = 0; i < 20000 && found == 0; i++) begin
         s = $urandom();
         if (s != 32'd0) begin
            model_fill(s, s_end, tmp_set, c, br, pr);
            if (br == 1 && pr == 1) found = 1;
         end
      end
      check_int("t3_seed_found", found, 1);
      load_seed(s);
      next_fill(1'b0, cyc);
      check_int("t3_len", cyc, 26);
      do_take();
      @(negedge clk); #1;
      zeros = 0;
      for (int i = 0; i < N_RAND; i++) if (random_vect_o[i] == 8'd0) zeros++;
      check_int("t3_no_zero_byte", zeros, 0);
      check_int("t3_p_range", int'(p_det_o < 5'd30), 1);

      // T4 seed load mid-fill, then seed 0 reproduces the default sequence
      repeat (9) @(posedge clk);
      #1;
      load_seed(32'h1234_5678);
      next_fill(1'b0, cyc);
      do_take();
      repeat (5) @(posedge clk);
      #1;
      load_seed(32'd0);
      next_fill(1'b0, cyc);
      check("seed0_default", cur_set, def_set);
      do_take();
      next_fill(1'b0, cyc);

      // T5 take and seed load together in READY
      seed_i = $urandom();
      seed_load_i = 1'b1;
      take_i = 1'b1;
      @(posedge clk); #1;
      seed_load_i = 1'b0;
      take_i = 1'b0;
      m_lfsr = (seed_i == 32'd0) ? SEED_DEF : seed_i;
      check_int("t5_valid", int'(valid_o), 0);
      check("t5_out_unchanged", {random_vect_o, p_det_o}, cur_out);
      next_fill(1'b0, cyc);
      do_take();

      // randomised rounds: seed loads at random fill points, READY holds of random length
      for (int r = 0; r < 8; r++) begin
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #1;
            load_seed(($urandom_range(0, 3) == 0) ? 32'd0 : $urandom());
         end
         next_fill(1'($urandom_range(0, 1)), cyc);
         repeat ($urandom_range(0, 5)) @(posedge clk);
         #1;
         check_int("ready_hold", int'(valid_o), 1);
         do_take();
      end
      next_fill(1'b0, cyc);

      // T6 reset while READY
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("t6_out", {random_vect_o, p_det_o}, '0);
      check_int("t6_valid", int'(valid_o), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      m_lfsr = SEED_DEF;
      cur_out = '0;
      next_fill(1'b0, cyc);
      check("t6_default_again", cur_set, def_set);
      do_take();

      repeat (3) @(posedge clk);
      #1;
      check_int("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
